// File: rtl/cs_phase_pkg.sv
// Shared types and constants for the charge-sharing phase generator.
// Holds the FSM state encoding and the minimum phase length.
package cs_phase_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HI      = 3'd1,
        ST_DEAD_HL = 3'd2,
        ST_LO      = 3'd3,
        ST_DEAD_LH = 3'd4
    } state_e;

    localparam int MIN_PHASE = 1;

endpackage

// File: rtl/cs_phase_gen_if.sv
// Load/terminal handshake between the phase FSM and its timer.
// The FSM side is the master; the timer side is the slave.
interface cs_phase_gen_if #(
    parameter int W = 8
);
    logic         load;
    logic [W-1:0] load_val;
    logic         done;

    modport master (output load, output load_val, input done);
    modport slave  (input load, input load_val, output done);
endinterface

// File: rtl/cs_phase_timer.sv
// Down-counting phase timer: load value-1, count to zero.
// done is high on the last clock of the current phase.
module cs_phase_timer #(
    parameter int W = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    cs_phase_gen_if.slave   tmr
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Load has priority; otherwise count down and park at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (tmr.load) begin
            cnt_d = tmr.load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tmr.done = (cnt_q == '0);

endmodule

// File: rtl/cs_phase_gen.sv
// Non-overlapping hi/lo phase generator with dead time and bursts.
// Outputs are registered from the next state so they align with it.
module cs_phase_gen
    import cs_phase_pkg::*;
#(
    parameter int N_CH    = 2,
    parameter int CNT_W   = 8,
    parameter int BURST_W = 8
) (
    input  logic               i_sys_clk,
    input  logic               i_reset_n,
    input  logic               i_enable,
    input  logic [CNT_W-1:0]   i_half_period,
    input  logic [CNT_W-1:0]   i_dead_time,
    input  logic [BURST_W-1:0] i_burst_len,
    input  logic [N_CH-1:0]    i_ch_en,
    input  logic [N_CH-1:0]    i_swap,
    output logic [N_CH-1:0]    o_cs_cell_hi,
    output logic [N_CH-1:0]    o_cs_cell_lo,
    output logic               o_busy,
    output logic               o_done
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   h_q, h_d, d_q, d_d;
    logic [CNT_W-1:0]   h_in, d_in;
    logic [N_CH-1:0]    ch_en_q, ch_en_d;
    logic [N_CH-1:0]    swap_q, swap_d;
    logic [BURST_W-1:0] burst_q, burst_d;
    logic [BURST_W-1:0] pcnt_q, pcnt_d, pcnt_inc;
    logic [N_CH-1:0]    hi_q, hi_d, lo_q, lo_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               enter_hi;
    logic               last_period;

    cs_phase_gen_if #(.W(CNT_W)) tmr ();

    cs_phase_timer #(.W(CNT_W)) u_timer (
        .clk   (i_sys_clk),
        .rst_n (i_reset_n),
        .tmr   (tmr)
    );

    // Zero lengths would collapse a phase, so clamp to one clock.
    assign h_in = (i_half_period == '0) ? CNT_W'(MIN_PHASE) : i_half_period;
    assign d_in = (i_dead_time == '0) ? CNT_W'(MIN_PHASE) : i_dead_time;

    // Saturate so continuous mode never wraps into a false burst match.
    assign pcnt_inc    = (pcnt_q == '1) ? pcnt_q : pcnt_q + BURST_W'(1);
    assign last_period = (burst_q != '0) && (pcnt_inc == burst_q);

    // Next-state, timer reload and configuration latching.
    always_comb begin
        state_d      = state_q;
        h_d          = h_q;
        d_d          = d_q;
        ch_en_d      = ch_en_q;
        swap_d       = swap_q;
        burst_d      = burst_q;
        pcnt_d       = pcnt_q;
        enter_hi     = 1'b0;
        tmr.load     = 1'b0;
        tmr.load_val = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (i_enable) begin
                    state_d  = ST_HI;
                    enter_hi = 1'b1;
                    burst_d  = i_burst_len;
                    pcnt_d   = '0;
                end
            end
            ST_HI: begin
                if (tmr.done) begin
                    state_d      = ST_DEAD_HL;
                    tmr.load     = 1'b1;
                    tmr.load_val = d_q - CNT_W'(1);
                end
            end
            ST_DEAD_HL: begin
                if (tmr.done) begin
                    state_d      = ST_LO;
                    tmr.load     = 1'b1;
                    tmr.load_val = h_q - CNT_W'(1);
                end
            end
            ST_LO: begin
                if (tmr.done) begin
                    state_d      = ST_DEAD_LH;
                    tmr.load     = 1'b1;
                    tmr.load_val = d_q - CNT_W'(1);
                end
            end
            ST_DEAD_LH: begin
                if (tmr.done) begin
                    pcnt_d = pcnt_inc;
                    if (!i_enable || last_period) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d  = ST_HI;
                        enter_hi = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (enter_hi) begin
            h_d          = h_in;
            d_d          = d_in;
            ch_en_d      = i_ch_en;
            swap_d       = i_swap;
            tmr.load     = 1'b1;
            tmr.load_val = h_in - CNT_W'(1);
        end
    end

    // Per-channel decode from the next state and the config it will use.
    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        assign hi_d[c] = ch_en_d[c] &
            (swap_d[c] ? (state_d == ST_LO) : (state_d == ST_HI));
        assign lo_d[c] = ch_en_d[c] &
            (swap_d[c] ? (state_d == ST_HI) : (state_d == ST_LO));
    end

    assign busy_d = (state_d != ST_IDLE);
    assign done_d = (state_q == ST_DEAD_LH) && (state_d == ST_IDLE);

    // FSM state, latched configuration and period counter.
    always_ff @(posedge i_sys_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= ST_IDLE;
            h_q     <= '0;
            d_q     <= '0;
            ch_en_q <= '0;
            swap_q  <= '0;
            burst_q <= '0;
            pcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            h_q     <= h_d;
            d_q     <= d_d;
            ch_en_q <= ch_en_d;
            swap_q  <= swap_d;
            burst_q <= burst_d;
            pcnt_q  <= pcnt_d;
        end
    end

    // Registered drive outputs, cleared straight away by reset.
    always_ff @(posedge i_sys_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            hi_q   <= '0;
            lo_q   <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign o_cs_cell_hi = hi_q;
    assign o_cs_cell_lo = lo_q;
    assign o_busy       = busy_q;
    assign o_done       = done_q;

endmodule

// File: doc/cs_phase_gen.md
CS_PHASE_GEN -- requirements
Module: cs_phase_gen

Interface
REQ-001 The block SHALL have parameter N_CH, default 2, meaning number of hi/lo output channel pairs.
REQ-002 The block SHALL have parameter CNT_W, default 8, meaning width of the half-period and dead-time fields.
REQ-003 The block SHALL have parameter BURST_W, default 8, meaning width of the burst period count.
REQ-004 The block SHALL have port i_sys_clk  input  1  system clock, with all logic on the rising edge.
REQ-005 The block SHALL have port i_reset_n  input  1  reset, asynchronous and active-low.
REQ-006 The block SHALL have port i_enable  input  1  run request, level-sensitive.
REQ-007 The block SHALL have port i_half_period  input  CNT_W  HI/LO phase length in clocks.
REQ-008 The block SHALL have port i_dead_time  input  CNT_W  non-overlap gap length in clocks.
REQ-009 The block SHALL have port i_burst_len  input  BURST_W  number of periods per run, where 0 means continuous.
REQ-010 The block SHALL have port i_ch_en  input  N_CH  per-channel enable mask.
REQ-011 The block SHALL have port i_swap  input  N_CH  per-channel hi/lo swap mask.
REQ-012 The block SHALL have port o_cs_cell_hi  output  N_CH  high-side drive per channel.
REQ-013 The block SHALL have port o_cs_cell_lo  output  N_CH  low-side drive per channel.
REQ-014 The block SHALL have port o_busy  output  1  state is not IDLE.
REQ-015 The block SHALL have port o_done  output  1  one-clock pulse on a burst or stop completion.

Function
REQ-016 The block SHALL implement a single shared FSM with states IDLE, HI, DEAD_HL, LO and DEAD_LH, plus one CNT_W phase counter and one BURST_W period counter.
REQ-017 The effective phase length SHALL be H = max(i_half_period, 1) and the effective gap SHALL be D = max(i_dead_time, 1); period = 2H + 2D clocks.
REQ-018 The block SHALL latch H, D, i_ch_en and i_swap on every entry to HI, and shall ignore changes between entries.
REQ-019 The block SHALL latch i_burst_len only on the IDLE->HI transition.
REQ-020 In IDLE with i_enable=1 at a rising edge, the state SHALL become HI at that edge.
REQ-021 The state sequence SHALL be HI for H clocks -> DEAD_HL for D clocks -> LO for H clocks -> DEAD_LH for D clocks.
REQ-022 At the end of DEAD_LH, the state SHALL return to HI unless a stop condition holds, in which case it SHALL go to IDLE.
REQ-023 The stop condition SHALL be either i_enable=0 sampled at the last DEAD_LH clock, or a nonzero latched burst with the completed-period count equal to burst_len.
REQ-024 Deasserting i_enable mid-period SHALL NOT truncate the period; the period SHALL always complete.
REQ-025 Outputs SHALL be registered and decoded from the next state, so o_cs_cell_hi rises on the same edge that HI is entered.
REQ-026 Channel c SHALL drive hi=1 only in HI and lo=1 only in LO, when ch_en[c]=1 and swap[c]=0; swap[c]=1 SHALL exchange the hi and lo outputs.
REQ-027 Disabled channels, and all channels in IDLE or in either DEAD state, SHALL drive hi=0 and lo=0.
REQ-028 o_cs_cell_hi[c] and o_cs_cell_lo[c] SHALL never be 1 in the same clock.
REQ-029 At least one clock of both-low SHALL separate every hi/lo edge, guaranteed by D >= 1.
REQ-030 o_done SHALL pulse for exactly one clock on the clock IDLE is entered from DEAD_LH.
REQ-031 o_busy SHALL be high in every non-IDLE state.
REQ-032 With i_enable held high in IDLE after a burst completes, the block SHALL restart on the next edge.
REQ-033 The period counter SHALL saturate at its maximum value in continuous mode; it SHALL NOT wrap into a false stop.

Reset
REQ-034 With i_reset_n=0, the block SHALL immediately force state IDLE and clear all counters and latched configuration.
REQ-035 With i_reset_n=0, the block SHALL immediately drive o_cs_cell_hi=0, o_cs_cell_lo=0, o_busy=0 and o_done=0, regardless of the clock.
REQ-036 Reset asserted mid-period SHALL drop all outputs low immediately, with no graceful completion.
REQ-037 After reset release, the first possible HI entry SHALL occur on the first rising edge that sees i_enable=1.

Structure
REQ-038 The package cs_phase_pkg SHALL hold the FSM state type, the state encodings, and the constant MIN_PHASE=1.
REQ-039 The phase timer (load, decrement, terminal flag) SHALL be one sub-module, cs_phase_timer, instantiated once.
REQ-040 Channel decode SHALL be a generate loop over N_CH inside cs_phase_gen.

Verification
REQ-041 Bench 1: reset, half=3, dead=1, burst=0, en=1, ch_en=2'b11, swap=0 -> period 8 clocks, with hi high 3 / low 5 and lo offset by 4 clocks.
REQ-042 Bench 2: burst=2, half=2, dead=2 -> exactly two periods (16 clocks), then o_done pulses once and o_busy falls on the same clock.
REQ-043 Bench 3: half=0, dead=0 -> treated as H=1, D=1, giving a period of 4 clocks with no hi/lo overlap on any clock.
REQ-044 Bench 4: swap=2'b10, ch_en=2'b01 -> ch0 normal, ch1 both outputs low; with ch_en=2'b11 applied mid-period, ch1 shows swapped outputs starting at the next HI entry only.
REQ-045 Bench 5: i_enable dropped during HI of period 3 -> period 3 completes, IDLE is entered at its end, and o_done pulses.
REQ-046 Bench 6: i_reset_n pulsed low during LO -> outputs go 0 the same timestep, IDLE holds until en is seen after release, and an assertion checks hi&lo==0 on all clocks in all scenarios.
